frame_sequencer: RTL

- Drives the timing side of the length counter.
- Divides the system clock into the 512 Hz frame sequencer and steps through its 8-step pattern.
- Emits one-cycle enable pulses for the length counters (256 Hz), the sweep unit (128 Hz) and the volume envelopes (64 Hz).
- All channel blocks run on `clk` and qualify their updates with these ticks; no derived clocks are used.

---
 rtl/apu_pkg.sv | 15 +
 rtl/frame_sequencer_prescaler.sv | 34 +++
 rtl/frame_sequencer.sv | 72 +++++++
 3 files changed

// File: rtl/apu_pkg.sv
// Shared APU definitions: step-index type, per-step tick masks and default divider.
package apu_pkg;

  // Frame sequencer step index, 0..7.
  typedef logic [2:0] stepIdx_t;

  // Bit n set means the tick fires when step n executes.
  localparam logic [7:0] LENGTH_STEP_MASK = 8'b0101_0101;
  localparam logic [7:0] SWEEP_STEP_MASK  = 8'b0100_0100;
  localparam logic [7:0] ENV_STEP_MASK    = 8'b1000_0000;

  // 4.194304 MHz / 512 Hz.
  localparam int unsigned DEFAULT_CLK_DIV = 8192;

endpackage

// File: rtl/frame_sequencer_prescaler.sv
// Free-running divider: counts 0..CLK_DIV-1 and flags the last count as the wrap.
module frame_sequencer_prescaler #(
  parameter int unsigned CLK_DIV   = 8192,
  parameter int unsigned DIV_WIDTH = 13
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  output logic wrap
);

  localparam logic [DIV_WIDTH-1:0] LastCount = DIV_WIDTH'(CLK_DIV - 1);

  logic [DIV_WIDTH-1:0] countQ, countD;

  // Wrap is suppressed while clear so a disable in the event cycle wins.
  always_comb begin
    wrap   = (countQ == LastCount) && !clear;
    countD = countQ + DIV_WIDTH'(1);
    if (clear || wrap) begin
      countD = '0;
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      countQ <= '0;
    end else begin
      countQ <= countD;
    end
  end

endmodule

// File: rtl/frame_sequencer.sv
// APU frame sequencer: 512 Hz step counter producing length, sweep and envelope ticks.
module frame_sequencer
  import apu_pkg::*;
#(
  parameter int unsigned CLK_DIV   = DEFAULT_CLK_DIV,
  parameter int unsigned DIV_WIDTH = 13
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       apu_enable,
  output logic       length_tick,
  output logic       sweep_tick,
  output logic       envelope_tick,
  output logic [2:0] step
);

  logic     stepEvent;
  logic     clear;
  stepIdx_t stepQ, stepD;
  logic     lengthQ, lengthD;
  logic     sweepQ, sweepD;
  logic     envQ, envD;

  assign clear = !apu_enable;

  frame_sequencer_prescaler #(
    .CLK_DIV   (CLK_DIV),
    .DIV_WIDTH (DIV_WIDTH)
  ) uPrescaler (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (clear),
    .wrap  (stepEvent)
  );

  // Advance the step on each event and decode the executed step into ticks.
  always_comb begin
    stepD   = stepQ;
    lengthD = 1'b0;
    sweepD  = 1'b0;
    envD    = 1'b0;
    if (clear) begin
      stepD = '0;
    end else if (stepEvent) begin
      stepD   = stepQ + stepIdx_t'(1);
      lengthD = LENGTH_STEP_MASK[stepQ];
      sweepD  = SWEEP_STEP_MASK[stepQ];
      envD    = ENV_STEP_MASK[stepQ];
    end
  end

  // Step and tick registers; ticks live for one cycle after the event edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stepQ   <= '0;
      lengthQ <= 1'b0;
      sweepQ  <= 1'b0;
      envQ    <= 1'b0;
    end else begin
      stepQ   <= stepD;
      lengthQ <= lengthD;
      sweepQ  <= sweepD;
      envQ    <= envD;
    end
  end

  assign step          = stepQ;
  assign length_tick   = lengthQ;
  assign sweep_tick    = sweepQ;
  assign envelope_tick = envQ;

endmodule
